axil_cfg_slave: RTL and testbench

- AXI4-Lite responder (slave) that terminates the test-side AXI4-Lite initiator traffic and exposes a bank of 32-bit configuration registers plus an interrupt status/enable pair.
- Sits behind the top-level axi4_slave_* pins as the register target for AXI-Lite config accesses.
- Drives a level interrupt output.
- Supports one outstanding write and one outstanding read; the read and write channels are independent.

---
 rtl/axil_cfg_slave.sv | 187 ++++++++++++++++++
 tb/tb_axil_cfg_slave.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cfg_slave.sv
// AXI4-Lite configuration register slave: ISR (reg 0, W1C), IER (reg 1), plain RW regs 2..NUM_REGS-1.
// Optional macro AXIL_CFG_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_cfg_slave #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IRQ_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_WIDTH-1:0]    awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [DATA_WIDTH/8-1:0]  wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDR_WIDTH-1:0]    araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic [IRQ_WIDTH-1:0]     irq_set,
  output logic [32*NUM_REGS-1:0]   cfg_regs,
  output logic                     interrupt
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [31:0] IRQ_MASK = (IRQ_WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << IRQ_WIDTH) - 32'd1);
  localparam logic [IDX_W:0] NUM_REGS_IDX = (IDX_W + 1)'(NUM_REGS);

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_RESP } r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic [31:0]      regs_reg [NUM_REGS];
  logic             aw_held_reg, w_held_reg;
  logic [IDX_W-1:0] aw_idx_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       wstrb_reg;
  logic [1:0]       bresp_reg, rresp_reg;
  logic [31:0]      rdata_reg;
  logic             interrupt_reg;

  logic             commit, wr_en, ar_hs;
  logic [31:0]      wmask, isr_clr, irq_set_ext, rd_val;
  logic [IDX_W-1:0] ar_idx;
  logic             aw_oor, ar_oor;
  logic [1:0]       aw_resp, ar_resp;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wmask
      assign wmask[8*gi +: 8] = {8{wstrb_reg[gi]}};
    end
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_cfg
      assign cfg_regs[32*gi +: 32] = regs_reg[gi];
    end
  endgenerate

  assign ar_idx      = araddr[ADDR_WIDTH-1:2];
  assign aw_oor      = {1'b0, aw_idx_reg} >= NUM_REGS_IDX;
  assign ar_oor      = {1'b0, ar_idx} >= NUM_REGS_IDX;
  assign wr_en       = commit && !aw_oor;
  assign irq_set_ext = 32'(irq_set);
  assign isr_clr     = (wr_en && aw_idx_reg == '0) ? (wdata_reg & wmask & IRQ_MASK) : 32'd0;

`ifdef AXIL_CFG_SLVERR_EN
  assign aw_resp = aw_oor ? 2'b10 : 2'b00;
  assign ar_resp = ar_oor ? 2'b10 : 2'b00;
`else
  assign aw_resp = 2'b00;
  assign ar_resp = 2'b00;
`endif

  always_comb begin
    rd_val = 32'd0;
    for (int i = 0; i < NUM_REGS; i++)
      if (!ar_oor && ar_idx == IDX_W'(i)) rd_val = regs_reg[i];
  end

  // Write channel: AW and W latch independently; commit once both are held.
  always_comb begin
    w_state_next = w_state_reg;
    commit       = 1'b0;
    awready      = (w_state_reg == W_IDLE) && !aw_held_reg;
    wready       = (w_state_reg == W_IDLE) && !w_held_reg;
    bvalid       = (w_state_reg == W_RESP);
    case (w_state_reg)
      W_IDLE: if (aw_held_reg && w_held_reg) begin
        commit       = 1'b1;
        w_state_next = W_RESP;
      end
      W_RESP: if (bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state_reg <= W_IDLE;
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      aw_idx_reg  <= '0;
      wdata_reg   <= 32'd0;
      wstrb_reg   <= 4'd0;
      bresp_reg   <= 2'b00;
    end else begin
      w_state_reg <= w_state_next;
      if (awvalid && awready) begin
        aw_held_reg <= 1'b1;
        aw_idx_reg  <= awaddr[ADDR_WIDTH-1:2];
      end
      if (wvalid && wready) begin
        w_held_reg <= 1'b1;
        wdata_reg  <= wdata;
        wstrb_reg  <= wstrb;
      end
      if (commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bresp_reg   <= aw_resp;
      end
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    arready      = (r_state_reg == R_IDLE);
    rvalid       = (r_state_reg == R_RESP);
    ar_hs        = 1'b0;
    case (r_state_reg)
      R_IDLE: if (arvalid) begin
        ar_hs        = 1'b1;
        r_state_next = R_RESP;
      end
      R_RESP: if (rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state_reg <= R_IDLE;
      rdata_reg   <= 32'd0;
      rresp_reg   <= 2'b00;
    end else begin
      r_state_reg <= r_state_next;
      if (ar_hs) begin
        rdata_reg <= rd_val;
        rresp_reg <= ar_resp;
      end
    end
  end

  // ISR set pulses are OR'd after the W1C clear so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= 32'd0;
      interrupt_reg <= 1'b0;
    end else begin
      regs_reg[0] <= ((regs_reg[0] & ~isr_clr) | irq_set_ext) & IRQ_MASK;
      if (wr_en && aw_idx_reg == IDX_W'(1))
        regs_reg[1] <= ((regs_reg[1] & ~wmask) | (wdata_reg & wmask)) & IRQ_MASK;
      for (int i = 2; i < NUM_REGS; i++)
        if (wr_en && aw_idx_reg == IDX_W'(i))
          regs_reg[i] <= (regs_reg[i] & ~wmask) | (wdata_reg & wmask);
      interrupt_reg <= |(regs_reg[0] & regs_reg[1]);
    end
  end

  assign bresp     = bresp_reg;
  assign rdata     = rdata_reg;
  assign rresp     = rresp_reg;
  assign interrupt = interrupt_reg;

endmodule

// File: tb/tb_axil_cfg_slave.sv
// Directed self-checking bench for axil_cfg_slave (default 13-bit address, 16 regs, 8 IRQ sources).
module tb_axil_cfg_slave;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [12:0]  awaddr = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [12:0]  araddr = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [7:0]   irq_set = '0;
  logic [511:0] cfg_regs;
  logic         interrupt;

  int checks = 0;
  int errors = 0;

`ifdef AXIL_CFG_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  axil_cfg_slave dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .irq_set(irq_set), .cfg_regs(cfg_regs), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [12:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done;
    bit w_done;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      step();
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin step(); n++; end
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL write_timeout addr=%h: bvalid=%b, required 1", addr, bvalid);
    end
    resp = bresp;
    bready = 1'b1; step(); bready = 1'b0;
    $display("write addr=%h data=%h strb=%h resp=%0d", addr, data, strb, resp);
  endtask

  task automatic axi_read(input logic [12:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    n = 0;
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < 20) begin step(); n++; end
    step();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin step(); n++; end
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL read_timeout addr=%h: rvalid=%b, required 1", addr, rvalid);
    end
    data = rdata; resp = rresp;
    rready = 1'b1; step(); rready = 1'b0;
    $display("read  addr=%h data=%h resp=%0d", addr, data, resp);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, interrupt} !== 6'b111000) begin
      errors++;
      $display("FAIL reset_ctrl: aw/w/ar/b/r/irq=%b, required 111000",
               {awready, wready, arready, bvalid, rvalid, interrupt});
    end
    checks++;
    if (cfg_regs !== '0) begin errors++; $display("FAIL reset_regs: got %h, required 0", cfg_regs); end
    checks++;
    if ({rdata, bresp, rresp} !== 36'd0) begin
      errors++;
      $display("FAIL reset_resp: rdata=%h bresp=%0d rresp=%0d, required 0", rdata, bresp, rresp);
    end
    reset = 1'b1;
    step();
    $display("reset done");
  endtask

  task automatic test_write_same_cycle();
    awaddr = 13'h00C; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if ({bvalid, awready, wready} !== 3'b000) begin
      errors++;
      $display("FAIL sc_after_hs: bvalid/awready/wready=%b, required 000", {bvalid, awready, wready});
    end
    step();
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL sc_bvalid: bvalid=%b bresp=%0d, required 1/0", bvalid, bresp);
    end
    checks++;
    if (cfg_regs[127:96] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sc_cfg_reg3: got %h, required deadbeef", cfg_regs[127:96]);
    end
    bready = 1'b1; step(); bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++;
      $display("FAIL sc_b_done: bvalid=%b awready=%b wready=%b, required 0/1/1", bvalid, awready, wready);
    end
    araddr = 13'h00C; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rresp !== 2'b00 || arready !== 1'b0) begin
      errors++;
      $display("FAIL sc_read: rvalid=%b rdata=%h rresp=%0d arready=%b, required 1/deadbeef/0/0",
               rvalid, rdata, rresp, arready);
    end
    rready = 1'b1; step(); rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++;
      $display("FAIL sc_r_done: rvalid=%b arready=%b, required 0/1", rvalid, arready);
    end
    $display("same-cycle write/read reg3 done");
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp;
    axi_write(13'h008, 32'hAAAAAAAA, 4'hF, resp);
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    step(); step();
    checks++;
    if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
      errors++;
      $display("FAIL wfirst_wait: wready=%b awready=%b bvalid=%b, required 0/1/0", wready, awready, bvalid);
    end
    awaddr = 13'h008; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_early_b: bvalid=%b, required 0", bvalid); end
    step();
    checks++;
    if (bvalid !== 1'b1 || wready !== 1'b0 || cfg_regs[95:64] !== 32'hAA22AA44) begin
      errors++;
      $display("FAIL wfirst_commit: bvalid=%b wready=%b reg2=%h, required 1/0/aa22aa44",
               bvalid, wready, cfg_regs[95:64]);
    end
    step();
    checks++;
    if (bvalid !== 1'b1 || wready !== 1'b0) begin
      errors++;
      $display("FAIL wfirst_hold: bvalid=%b wready=%b, required 1/0", bvalid, wready);
    end
    bready = 1'b1; step(); bready = 1'b0;
    checks++;
    if (wready !== 1'b1 || awready !== 1'b1) begin
      errors++;
      $display("FAIL wfirst_done: wready=%b awready=%b, required 1/1", wready, awready);
    end
    $display("W-before-AW strobed write reg2 done");
  endtask

  task automatic test_irq();
    logic [1:0]  resp;
    logic [31:0] d;
    axi_write(13'h004, 32'h1, 4'hF, resp);
    irq_set = 8'h05;
    step();
    irq_set = 8'h00;
    checks++;
    if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_early: interrupt=%b, required 0", interrupt); end
    step();
    checks++;
    if (interrupt !== 1'b1 || cfg_regs[31:0] !== 32'h5) begin
      errors++;
      $display("FAIL irq_assert: interrupt=%b isr=%h, required 1/5", interrupt, cfg_regs[31:0]);
    end
    axi_write(13'h000, 32'h1, 4'hF, resp);
    checks++;
    if (interrupt !== 1'b0 || cfg_regs[31:0] !== 32'h4) begin
      errors++;
      $display("FAIL irq_w1c: interrupt=%b isr=%h, required 0/4", interrupt, cfg_regs[31:0]);
    end
    awaddr = 13'h000; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; irq_set = 8'h01;
    step();
    irq_set = 8'h00;
    checks++;
    if (bvalid !== 1'b1 || cfg_regs[31:0] !== 32'h5) begin
      errors++;
      $display("FAIL irq_set_wins: bvalid=%b isr=%h, required 1/5", bvalid, cfg_regs[31:0]);
    end
    bready = 1'b1; step(); bready = 1'b0;
    checks++;
    if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_reassert: interrupt=%b, required 1", interrupt); end
    axi_write(13'h004, 32'hFFFFFFFF, 4'hF, resp);
    axi_read(13'h004, d, resp);
    checks++;
    if (d !== 32'h000000FF) begin errors++; $display("FAIL ier_ro_bits: got %h, required 000000ff", d); end
    axi_write(13'h004, 32'h0, 4'hF, resp);
    axi_write(13'h000, 32'hFF, 4'hF, resp);
    checks++;
    if (cfg_regs[63:0] !== 64'd0) begin
      errors++;
      $display("FAIL irq_cleanup: isr/ier=%h, required 0", cfg_regs[63:0]);
    end
    $display("interrupt set/clear done");
  endtask

  task automatic test_out_of_range();
    logic [1:0]   resp;
    logic [31:0]  d;
    logic [511:0] exp_cfg;
    exp_cfg = '0;
    exp_cfg[95:64]  = 32'hAA22AA44;
    exp_cfg[127:96] = 32'hDEADBEEF;
    axi_write(13'h040, 32'h12345678, 4'hF, resp);
    checks++;
    if (resp !== OOR_RESP) begin errors++; $display("FAIL oor_bresp: got %0d, required %0d", resp, OOR_RESP); end
    checks++;
    if (cfg_regs !== exp_cfg) begin errors++; $display("FAIL oor_regs: got %h, required %h", cfg_regs, exp_cfg); end
    axi_read(13'h040, d, resp);
    checks++;
    if (d !== 32'd0 || resp !== OOR_RESP) begin
      errors++;
      $display("FAIL oor_read: rdata=%h rresp=%0d, required 0/%0d", d, resp, OOR_RESP);
    end
    $display("out-of-range access done");
  endtask

  task automatic test_read_backpressure();
    araddr = 13'h00C; arvalid = 1'b1;
    step();
    araddr = 13'h008;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || arready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: rvalid=%b rdata=%h arready=%b, required 1/deadbeef/0",
                 i, rvalid, rdata, arready);
      end
      step();
    end
    rready = 1'b1; step(); rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: rvalid=%b arready=%b, required 0/1", rvalid, arready);
    end
    step();
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hAA22AA44) begin
      errors++;
      $display("FAIL bp_second: rvalid=%b rdata=%h, required 1/aa22aa44", rvalid, rdata);
    end
    rready = 1'b1; step(); rready = 1'b0;
    $display("read backpressure done");
  endtask

  task automatic test_reset_midflight();
    logic [1:0]  resp;
    logic [31:0] d;
    axi_write(13'h004, 32'h2, 4'hF, resp);
    irq_set = 8'h02; step(); irq_set = 8'h00; step();
    checks++;
    if (interrupt !== 1'b1) begin errors++; $display("FAIL mid_pre_irq: interrupt=%b, required 1", interrupt); end
    awaddr = 13'h014; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_b: bvalid=%b, required 1", bvalid); end
    reset = 1'b0;
    step();
    checks++;
    if ({bvalid, awready, wready, arready, interrupt} !== 5'b01110) begin
      errors++;
      $display("FAIL mid_reset_ctrl: b/aw/w/ar/irq=%b, required 01110",
               {bvalid, awready, wready, arready, interrupt});
    end
    checks++;
    if (cfg_regs !== '0) begin errors++; $display("FAIL mid_reset_regs: got %h, required 0", cfg_regs); end
    reset = 1'b1;
    step();
    axi_read(13'h014, d, resp);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL mid_post_read: got %h, required 0", d); end
    $display("reset mid-transaction done");
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_irq();
    test_out_of_range();
    test_read_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
